sram_port_arbiter: RTL

//  Shares the single SRAM controller port between three requesters: CPU instruction fetch, CPU data

---
 rtl/sram_port_arbiter_pkg.sv | 36 +++
 rtl/sram_port_arbiter_prio_sel.sv | 38 +++
 rtl/sram_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM state encoding,
// requester IDs, one-hot grant codes and default tuning values.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] ID_I = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_V = 2'd2;

    // One-hot grant vector layout: bit 0 fetch, bit 1 data, bit 2 VGA
    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_I    = 3'b001;
    localparam logic [2:0] GNT_D    = 3'b010;
    localparam logic [2:0] GNT_V    = 3'b100;

    localparam int unsigned VGA_STREAK_MAX_DEF = 32'd4;
    localparam int unsigned TIMEOUT_DEF        = 32'd255;

    // Map a one-hot grant onto the requester ID latched for the access
    function automatic logic [1:0] gnt_to_id(input logic [2:0] gnt);
        logic [1:0] id;
        case (gnt)
            GNT_V:   id = ID_V;
            GNT_D:   id = ID_D;
            GNT_I:   id = ID_I;
            default: id = ID_I;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_prio_sel.sv
// arb_prio_sel: combinational grant select for the SRAM port arbiter.
// Ports:
//   v_req, d_req, i_req : pending requests (VGA, CPU data, CPU fetch)
//   streak_full         : VGA has used up its consecutive-grant allowance
//   grant               : one-hot winner (GNT_* layout), zero when idle
// Normal order is VGA > D > I; once the VGA streak is full any pending CPU
// request wins instead, data ahead of fetch.
module arb_prio_sel
    import sram_port_arbiter_pkg::*;
(
    input  logic       v_req,
    input  logic       d_req,
    input  logic       i_req,
    input  logic       streak_full,
    output logic [2:0] grant
);

    // Priority resolution
    always_comb begin
        grant = GNT_NONE;
        if (streak_full && (d_req || i_req)) begin
            if (d_req) begin
                grant = GNT_D;
            end else begin
                grant = GNT_I;
            end
        end else if (v_req) begin
            grant = GNT_V;
        end else if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end else begin
            grant = GNT_NONE;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM controller port between CPU fetch (i_*),
// CPU data (d_*) and the VGA framebuffer reader (v_*).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_/d_/v_ req,addr   : requester side; d_we/d_wdata for data writes
//   *_rdata, *_rdy      : per-requester read data and 1-cycle completion pulse
//   mem_*               : controller side (request, write strobe, address,
//                         write data, read data, completion)
//   cpu_stall           : CPU has an access that has not yet completed
//   err_timeout         : sticky watchdog flag, cleared only by rst
// One access at a time: IDLE picks a winner, BUSY holds the latched access
// until mem_rdy or the watchdog fires, DONE gives requesters a cycle to
// drop or change their request.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32'd32,
    parameter int unsigned DATA_W         = 32'd32,
    parameter int unsigned VGA_STREAK_MAX = VGA_STREAK_MAX_DEF,
    parameter int unsigned TIMEOUT        = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rdy,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rdy,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic [DATA_W-1:0] v_rdata,
    output logic              v_rdy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              cpu_stall,
    output logic              err_timeout
);

    localparam logic [3:0] STREAK_MAX_C = VGA_STREAK_MAX[3:0];
    // Abort on the last permitted BUSY cycle so mem_req stays high for exactly TIMEOUT cycles
    localparam logic [7:0] WDOG_LAST_C  = TIMEOUT[7:0] - 8'd1;

    arb_state_e        state_r, state_nx_s;
    logic [3:0]        streak_r;
    logic [7:0]        wdog_r;
    logic [1:0]        id_r;
    logic [2:0]        grant_s;
    logic [1:0]        grant_id_s;
    logic              streak_full_s, cpu_pend_s;
    logic              start_s, complete_s, abort_s;
    logic [ADDR_W-1:0] lat_addr_s;
    logic              lat_we_s;
    logic [DATA_W-1:0] lat_wdata_s;
    logic [DATA_W-1:0] fin_data_s;

    logic              mem_req_r, mem_we_r, err_timeout_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              i_rdy_r, d_rdy_r, v_rdy_r;
    logic [DATA_W-1:0] i_rdata_r, d_rdata_r, v_rdata_r;

    assign cpu_pend_s    = d_req | i_req;
    assign streak_full_s = (streak_r == STREAK_MAX_C);
    assign grant_id_s    = gnt_to_id(grant_s);
    // Timeout completions return zero rather than whatever is on the bus
    assign fin_data_s    = complete_s ? mem_rdata : {DATA_W{1'b0}};

    arb_prio_sel u_prio_sel (
        .v_req       (v_req),
        .d_req       (d_req),
        .i_req       (i_req),
        .streak_full (streak_full_s),
        .grant       (grant_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and per-cycle transaction strobes
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (grant_s != GNT_NONE) begin
                    start_s    = 1'b1;
                    state_nx_s = S_BUSY;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mem_rdy) begin
                    complete_s = 1'b1;
                    state_nx_s = S_DONE;
                end else if (wdog_r == WDOG_LAST_C) begin
                    abort_s    = 1'b1;
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_BUSY;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Access fields captured from the winning requester
    always_comb begin
        lat_addr_s  = {ADDR_W{1'b0}};
        lat_we_s    = 1'b0;
        lat_wdata_s = {DATA_W{1'b0}};
        case (grant_id_s)
            ID_V: lat_addr_s = v_addr;
            ID_D: begin
                lat_addr_s  = d_addr;
                lat_we_s    = d_we;
                lat_wdata_s = d_wdata;
            end
            ID_I:    lat_addr_s = i_addr;
            default: lat_addr_s = {ADDR_W{1'b0}};
        endcase
    end

    // Bounded VGA priority: count VGA wins that made a CPU request wait
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= 4'd0;
        end else if (state_r == S_IDLE) begin
            if (!cpu_pend_s) begin
                streak_r <= 4'd0;
            end else if (grant_s == GNT_V) begin
                streak_r <= streak_r + 4'd1;
            end else begin
                streak_r <= 4'd0;
            end
        end
    end

    // Latched access, watchdog, completion pulses and read-data holding
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r          <= ID_I;
            wdog_r        <= 8'd0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            i_rdy_r       <= 1'b0;
            d_rdy_r       <= 1'b0;
            v_rdy_r       <= 1'b0;
            i_rdata_r     <= {DATA_W{1'b0}};
            d_rdata_r     <= {DATA_W{1'b0}};
            v_rdata_r     <= {DATA_W{1'b0}};
            err_timeout_r <= 1'b0;
        end else begin
            i_rdy_r <= 1'b0;
            d_rdy_r <= 1'b0;
            v_rdy_r <= 1'b0;
            if (start_s) begin
                id_r        <= grant_id_s;
                wdog_r      <= 8'd0;
                mem_req_r   <= 1'b1;
                mem_we_r    <= lat_we_s;
                mem_addr_r  <= lat_addr_s;
                mem_wdata_r <= lat_wdata_s;
            end else if (complete_s || abort_s) begin
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
                case (id_r)
                    ID_I: begin
                        i_rdy_r   <= 1'b1;
                        i_rdata_r <= fin_data_s;
                    end
                    ID_D: begin
                        d_rdy_r <= 1'b1;
                        // Writes keep the last read value visible
                        if (!mem_we_r) begin
                            d_rdata_r <= fin_data_s;
                        end
                    end
                    ID_V: begin
                        v_rdy_r   <= 1'b1;
                        v_rdata_r <= fin_data_s;
                    end
                    default: begin
                        i_rdy_r <= 1'b0;
                    end
                endcase
            end else if (state_r == S_BUSY) begin
                wdog_r <= wdog_r + 8'd1;
            end
            if (abort_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign i_rdy       = i_rdy_r;
    assign d_rdy       = d_rdy_r;
    assign v_rdy       = v_rdy_r;
    assign i_rdata     = i_rdata_r;
    assign d_rdata     = d_rdata_r;
    assign v_rdata     = v_rdata_r;
    assign err_timeout = err_timeout_r;
    assign cpu_stall   = (i_req & ~i_rdy_r) | (d_req & ~d_rdy_r);

endmodule
